// File: rtl/axi4_memory_responder.sv
// AXI4 slave backed by a synchronous on-chip RAM. The write (AW/W/B) and read (AR/R)
// channels run independent FSMs that share one RAM, one outstanding burst per channel.
module axi4_memory_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int ID_WIDTH       = 1,
  parameter int MEM_WORDS_LOG2 = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]              S_AXI_AWLEN,
  input  logic [1:0]              S_AXI_AWBURST,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WLAST,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]              S_AXI_ARLEN,
  input  logic [1:0]              S_AXI_ARBURST,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [ID_WIDTH-1:0]     S_AXI_RID,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RLAST,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rState_t;

  wState_t wState, wStateNext;
  rState_t rState, rStateNext;

  logic [DATA_WIDTH-1:0] mem [2**MEM_WORDS_LOG2];
  logic [DATA_WIDTH-1:0] rdWord;

  logic [ID_WIDTH-1:0]       wId, rId;
  logic [MEM_WORDS_LOG2-1:0] wIdx, rIdx;
  logic [7:0]                wLen, wBeat, rLen, rBeat;
  logic                      wIncr, rIncr, wErr, rErr, wPastLen;
  logic                      awHs, wHs, arHs, rHs, wrEn;
  logic                      unusedAddrBits;

  function automatic logic burstBad(input logic [1:0] burst);
    return !(burst == BURST_FIXED || burst == BURST_INCR);
  endfunction

  // Upper address bits and the in-word byte offset are dropped, so addresses alias.
  function automatic logic [MEM_WORDS_LOG2-1:0] wordIndex(input logic [ADDR_WIDTH-1:0] addr);
    return addr[MEM_WORDS_LOG2+OFF_W-1:OFF_W];
  endfunction

  assign unusedAddrBits = ^{S_AXI_AWADDR, S_AXI_ARADDR};

  assign awHs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign wHs  = S_AXI_WVALID && S_AXI_WREADY;
  assign arHs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign rHs  = S_AXI_RVALID && S_AXI_RREADY;
  assign wrEn = wHs && !wErr && !wPastLen;

  assign S_AXI_BID   = wId;
  assign S_AXI_BRESP = (wState == W_RESP && wErr) ? RESP_SLVERR : RESP_OKAY;
  assign S_AXI_RID   = rId;
  assign S_AXI_RRESP = (rState == R_DATA && rErr) ? RESP_SLVERR : RESP_OKAY;
  assign S_AXI_RDATA = (rState == R_DATA && !rErr) ? rdWord : '0;

  always_comb begin
    wStateNext    = wState;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    case (wState)
      W_IDLE: begin
        S_AXI_AWREADY = 1'b1;
        if (S_AXI_AWVALID) wStateNext = W_DATA;
      end
      W_DATA: begin
        S_AXI_WREADY = 1'b1;
        if (S_AXI_WVALID && S_AXI_WLAST) wStateNext = W_RESP;
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) wStateNext = W_IDLE;
      end
      default: wStateNext = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wState   <= W_IDLE;
      wId      <= '0;
      wErr     <= 1'b0;
      wPastLen <= 1'b0;
    end else begin
      wState <= wStateNext;
      if (awHs) begin
        wId      <= S_AXI_AWID;
        wErr     <= burstBad(S_AXI_AWBURST);
        wPastLen <= 1'b0;
      end else if (wHs) begin
        // Beats beyond AWLEN, or WLAST off the expected beat, poison the response.
        if (wPastLen || (S_AXI_WLAST && wBeat != wLen)) wErr <= 1'b1;
        if (wBeat == wLen) wPastLen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (awHs) begin
      wIdx  <= wordIndex(S_AXI_AWADDR);
      wIncr <= (S_AXI_AWBURST == BURST_INCR);
      wLen  <= S_AXI_AWLEN;
      wBeat <= 8'd0;
    end else if (wHs) begin
      if (wIncr) wIdx <= wIdx + 1'b1;
      if (!wPastLen && wBeat != wLen) wBeat <= wBeat + 8'd1;
    end
  end

  always_comb begin
    rStateNext    = rState;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    S_AXI_RLAST   = 1'b0;
    case (rState)
      R_IDLE: begin
        S_AXI_ARREADY = 1'b1;
        if (S_AXI_ARVALID) rStateNext = R_FETCH;
      end
      R_FETCH: rStateNext = R_DATA;
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        S_AXI_RLAST  = (rBeat == rLen);
        if (S_AXI_RREADY) rStateNext = (rBeat == rLen) ? R_IDLE : R_FETCH;
      end
      default: rStateNext = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rState <= R_IDLE;
      rId    <= '0;
      rErr   <= 1'b0;
    end else begin
      rState <= rStateNext;
      if (arHs) begin
        rId  <= S_AXI_ARID;
        rErr <= burstBad(S_AXI_ARBURST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arHs) begin
      rIdx  <= wordIndex(S_AXI_ARADDR);
      rIncr <= (S_AXI_ARBURST == BURST_INCR);
      rLen  <= S_AXI_ARLEN;
      rBeat <= 8'd0;
    end else if (rHs && !S_AXI_RLAST) begin
      if (rIncr) rIdx <= rIdx + 1'b1;
      rBeat <= rBeat + 8'd1;
    end
  end

  // Read and write in one block with non-blocking updates gives read-first on a collision.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (S_AXI_WSTRB[b]) mem[wIdx][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
      end
    end
    if (rState == R_FETCH) rdWord <= mem[rIdx];
  end

endmodule
